drap_mem_stage: RTL and testbench

DRAP_MEM_STAGE -- requirements
Module: drap_mem_stage

---
 rtl/drap_mem_stage.sv | 174 +++++++++++++++++
 tb/tb_drap_mem_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/drap_mem_stage.sv
// Load/store stage in front of a 16-word synchronous data memory: byte/half/word
// loads with extension and read-modify-write sub-word stores.
// Optional misaligned-access trapping is enabled with `define DRAP_MISALIGN_TRAP_EN.
module drap_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  ls_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [3:0]  mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_data_out,
  output logic        out_valid,
  output logic [31:0] load_data,
  output logic        misalign
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_LWAIT  = 2'd2;
  localparam logic [1:0] S_MERGE  = 2'd3;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  logic [1:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_q, load_d;
  logic        ovld_q, ovld_d;
  logic        rd_raw, wr_raw;
  logic        is_word, is_half, is_sub_store;
  logic [1:0]  lo_eff;
  logic [4:0]  lane_sh;
  logic [31:0] rdata_sh, merged, ext_load;
  logic        unused_addr;

  // Only addr[5:0] is latched; the rest of the address space aliases.
  assign unused_addr = ^addr[31:6];

  assign is_word      = (op_q == OP_LW) || (op_q == OP_SW);
  assign is_half      = (op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH);
  assign is_sub_store = (op_q == OP_SH) || (op_q == OP_SB);

  // Lane offset with the low address bits forced to the access's natural alignment.
  assign lo_eff   = is_word ? 2'b00 : (is_half ? {addr_q[1], 1'b0} : addr_q[1:0]);
  assign lane_sh  = {lo_eff, 3'b000};
  assign rdata_sh = mem_data_out >> lane_sh;

  always_comb begin
    merged = mem_data_out;
    if (op_q == OP_SH) merged[lane_sh +: 16] = wdata_q[15:0];
    else               merged[lane_sh +: 8]  = wdata_q[7:0];
  end

  always_comb begin
    ext_load = rdata_sh;
    case (op_q)
      OP_LH:   ext_load = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      OP_LHU:  ext_load = {16'h0000, rdata_sh[15:0]};
      OP_LB:   ext_load = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      OP_LBU:  ext_load = {24'h000000, rdata_sh[7:0]};
      default: ext_load = rdata_sh;
    endcase
  end

`ifdef DRAP_MISALIGN_TRAP_EN
  logic mis_q, mis_d, mis_hit;
  assign mis_hit  = (is_word && (addr_q[1:0] != 2'b00)) || (is_half && addr_q[0]);
  assign misalign = mis_q;
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    load_d      = load_q;
    ovld_d      = 1'b0;
    rd_raw      = 1'b0;
    wr_raw      = 1'b0;
    mem_data_in = 32'h0;
`ifdef DRAP_MISALIGN_TRAP_EN
    mis_d       = mis_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = ls_op;
          addr_d  = addr[5:0];
          wdata_d = wdata;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
`ifdef DRAP_MISALIGN_TRAP_EN
        mis_d = 1'b0;
        if (mis_hit) begin
          mis_d   = 1'b1;
          load_d  = 32'h0;
          ovld_d  = 1'b1;
          state_d = S_IDLE;
        end else
`endif
        if (op_q == OP_SW) begin
          wr_raw      = 1'b1;
          mem_data_in = wdata_q;
          ovld_d      = 1'b1;
          state_d     = S_IDLE;
        end else begin
          rd_raw  = 1'b1;
          state_d = is_sub_store ? S_MERGE : S_LWAIT;
        end
      end
      S_LWAIT: begin
        load_d  = ext_load;
        ovld_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        wr_raw      = 1'b1;
        mem_data_in = merged;
        ovld_d      = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      addr_q  <= 6'h00;
      wdata_q <= 32'h0;
      load_q  <= 32'h0;
      ovld_q  <= 1'b0;
`ifdef DRAP_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      ovld_q  <= ovld_d;
`ifdef DRAP_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // Strobes are gated by reset so an interrupted RMW never writes.
  assign mem_read    = rd_raw & ~rst;
  assign mem_write   = wr_raw & ~rst;
  assign mem_address = addr_q[5:2];
  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = ovld_q;
  assign load_data   = load_q;

endmodule

// File: tb/tb_drap_mem_stage.sv
// Bench for drap_mem_stage: directed vector table, reset-during-RMW sequence and
// randomized ops against a word-array reference model of the memory stage.
module tb_drap_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ls_op;
  logic [31:0] addr, wdata;
  logic [3:0]  mem_address;
  logic [31:0] mem_data_in;
  logic        mem_write, mem_read;
  logic [31:0] mem_data_out;
  logic        out_valid;
  logic [31:0] load_data;
  logic        misalign;

  drap_mem_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ls_op(ls_op), .addr(addr), .wdata(wdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write(mem_write), .mem_read(mem_read), .mem_data_out(mem_data_out),
    .out_valid(out_valid), .load_data(load_data), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous write, read data registered one cycle after mem_read.
  logic [31:0] mem [16];
  logic [31:0] rd_q = 32'h0;
  initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_data_in;
    if (mem_read)  rd_q <= mem[mem_address];
  end
  assign mem_data_out = rd_q;

  int prot_err = 0;
  always @(negedge clk) begin
    if ((mem_read && mem_write) || (in_ready && (mem_read || mem_write))) begin
      prot_err++;
      $display("FAIL strobe_protocol: rd=%0b wr=%0b in_ready=%0b, required no overlap and idle quiet",
               mem_read, mem_write, in_ready);
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: memory as words, results from plain byte arithmetic.
  logic [31:0] ref_mem [16];
  logic [31:0] ref_ld;
  bit trap_en;

  task automatic ref_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] eld, output logic emis, output int elat);
    int w, b, size;
    logic [31:0] word, v;
    w    = int'(a[5:2]);
    b    = int'(a[1:0]);
    size = (op == 3'd0 || op == 3'd5) ? 4 : ((op == 3'd1 || op == 3'd2 || op == 3'd6) ? 2 : 1);
    emis = 1'b0;
    if (trap_en && (b % size) != 0) begin
      ref_ld = 32'h0;
      emis   = 1'b1;
      eld    = 32'h0;
      elat   = 2;
      return;
    end
    b    = b - (b % size);
    word = ref_mem[w];
    elat = (op == 3'd5) ? 2 : 3;
    if (op >= 3'd5) begin
      for (int k = 0; k < size; k++) word[8*(b+k) +: 8] = wd[8*k +: 8];
      ref_mem[w] = word;
    end else begin
      v = 32'h0;
      for (int k = 0; k < size; k++) v[8*k +: 8] = word[8*(b+k) +: 8];
      if (op == 3'd1 && v[15]) v = v | 32'hFFFF0000;
      if (op == 3'd3 && v[7])  v = v | 32'hFFFFFF00;
      ref_ld = v;
    end
    eld = ref_ld;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] ld, output logic mis, output int lat);
    @(negedge clk);
    if (!in_ready) begin
      fails++;
      $display("FAIL not_ready_before_issue: in_ready=0, required 1");
    end
    in_valid = 1'b1; ls_op = op; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    in_valid = 1'b0; ls_op = 3'($urandom); addr = $urandom; wdata = $urandom;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    ld  = load_data;
    mis = misalign;
    @(negedge clk);
    chk("out_valid_one_pulse", {31'h0, out_valid}, 32'h0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] eld;
    logic        emis;
    int          elat;
  } vec_t;

  vec_t vt [$];

  initial begin
    logic [31:0] ld, eld, a;
    logic        mis, emis;
    int          lat, elat;
    string       nm;

`ifdef DRAP_MISALIGN_TRAP_EN
    trap_en = 1'b1;
`else
    trap_en = 1'b0;
`endif
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    ref_ld = 32'h0;

    vt.push_back('{3'd5, 32'h00, 32'h55555555, 32'h00000000, 1'b0, 2});
    vt.push_back('{3'd0, 32'h00, 32'h0,        32'h55555555, 1'b0, 3});
    vt.push_back('{3'd5, 32'h3C, 32'hAAAAAAAA, 32'h55555555, 1'b0, 2});
    vt.push_back('{3'd7, 32'h3D, 32'h0000007F, 32'h55555555, 1'b0, 3});
    vt.push_back('{3'd0, 32'h3C, 32'h0,        32'hAAAA7FAA, 1'b0, 3});
    vt.push_back('{3'd3, 32'h3C, 32'h0,        32'hFFFFFFAA, 1'b0, 3});
    vt.push_back('{3'd4, 32'h3C, 32'h0,        32'h000000AA, 1'b0, 3});
    vt.push_back('{3'd5, 32'h04, 32'h12348765, 32'h000000AA, 1'b0, 2});
    vt.push_back('{3'd1, 32'h04, 32'h0,        32'hFFFF8765, 1'b0, 3});
    vt.push_back('{3'd2, 32'h06, 32'h0,        32'h00001234, 1'b0, 3});
    vt.push_back('{3'd6, 32'h06, 32'h0000BEEF, 32'h00001234, 1'b0, 3});
    vt.push_back('{3'd0, 32'h04, 32'h0,        32'hBEEF8765, 1'b0, 3});
    vt.push_back('{3'd5, 32'h40, 32'h01020304, 32'hBEEF8765, 1'b0, 2});
    vt.push_back('{3'd0, 32'h00, 32'h0,        32'h01020304, 1'b0, 3});
`ifdef DRAP_MISALIGN_TRAP_EN
    vt.push_back('{3'd0, 32'h02, 32'h0,        32'h00000000, 1'b1, 2});
`else
    vt.push_back('{3'd0, 32'h02, 32'h0,        32'h01020304, 1'b0, 3});
`endif

    rst = 1'b1; in_valid = 1'b0; ls_op = 3'd0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready",  {31'h0, in_ready},  32'h1);
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_load_data", load_data,          32'h0);
    chk("reset_misalign",  {31'h0, misalign},  32'h0);
    chk("reset_strobes",   {30'h0, mem_read, mem_write}, 32'h0);

    foreach (vt[i]) begin
      ref_exec(vt[i].op, vt[i].a, vt[i].wd, eld, emis, elat);
      run_op(vt[i].op, vt[i].a, vt[i].wd, ld, mis, lat);
      nm = $sformatf("vec%0d", i);
      chk({nm, "_load_data"}, ld, vt[i].eld);
      chk({nm, "_misalign"}, {31'h0, mis}, {31'h0, vt[i].emis});
      chk({nm, "_latency"}, 32'(lat), 32'(vt[i].elat));
    end

    // Reset asserted during the MERGE cycle of an SB must not write memory.
    ref_exec(3'd5, 32'h10, 32'h11223344, eld, emis, elat);
    run_op(3'd5, 32'h10, 32'h11223344, ld, mis, lat);
    @(negedge clk);
    in_valid = 1'b1; ls_op = 3'd7; addr = 32'h11; wdata = 32'h000000EE;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rmw_access_read", {31'h0, mem_read}, 32'h1);
    @(negedge clk);
    chk("rmw_merge_write_raw", {31'h0, mem_write}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rmw_reset_gates_write", {31'h0, mem_write}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    ref_ld = 32'h0;
    @(negedge clk);
    chk("rmw_reset_in_ready",  {31'h0, in_ready},  32'h1);
    chk("rmw_reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rmw_reset_load_data", load_data,          32'h0);
    chk("rmw_word_unchanged",  mem[4],             32'h11223344);

    for (int n = 0; n < 80; n++) begin
      logic [2:0]  op;
      logic [31:0] wd;
      op = 3'($urandom);
      a  = $urandom;
      a[5:2] = 4'($urandom_range(0, 3)) + (n[0] ? 4'd12 : 4'd0);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      wd = $urandom;
      ref_exec(op, a, wd, eld, emis, elat);
      run_op(op, a, wd, ld, mis, lat);
      nm = $sformatf("rnd%0d_op%0d_a%02h", n, op, a[5:0]);
      chk({nm, "_load_data"}, ld, eld);
      chk({nm, "_misalign"}, {31'h0, mis}, {31'h0, emis});
      chk({nm, "_latency"}, 32'(lat), 32'(elat));
    end

    for (int w = 0; w < 16; w++) chk($sformatf("mem_word%0d", w), mem[w], ref_mem[w]);
    chk("strobe_protocol_errors", 32'(prot_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
